fetch_sequencer: RTL and testbench

Program-counter sequencer for the RV32I fetch unit. Drives the address of the combinational `InstructionMemory` and registers the returned word into a one-deep valid/ready output stage toward decode. Supports backpressure, branch/jump redirects from execute, and halts with a sticky fault on a misaligned or out-of-range fetch address.

---
 rtl/fetch_sequencer.sv | 135 +++++++++++++
 tb/tb_fetch_sequencer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Purpose : RV32I fetch program counter. Addresses a combinational instruction
//           memory and registers the returned word into a one-deep valid/ready
//           stage toward decode. Handles redirects and misaligned/out-of-range
//           fetch addresses; a bad address raises a sticky fault.
// Latency : The memory read and the output capture happen in the same cycle.
//           After reset, the first fetch is valid two edges after rst falls.
//           A redirect delivers its target one edge after it is sampled.
// Backpressure: With fetchValid=1 and fetchReady=0, the PC and the output
//           register hold, so the memory word stays stable. No fetch is dropped.
// Ports   : clk, rst (synchronous, active-high)
//           instructionAddress -> memory address (the current pc)
//           instruction        <- memory data (combinational)
//           redirectValid/redirectTarget <- branch or jump from execute
//           fetchValid/fetchReady/fetchInstr/fetchPC -> decode handshake
//           fault/faultAddress -> sticky fetch fault and the PC that caused it
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_BYTES = 256
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] instructionAddress,
  input  logic [31:0] instruction,
  input  logic        redirectValid,
  input  logic [31:0] redirectTarget,
  output logic        fetchValid,
  input  logic        fetchReady,
  output logic [31:0] fetchInstr,
  output logic [31:0] fetchPC,
  output logic        fault,
  output logic [31:0] faultAddress
);

  localparam logic [31:0] IMEM_LIMIT = 32'(IMEM_BYTES);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] pc;

  // The output register can take a new word when it is empty or is being
  // drained this cycle.
  logic advance;
  logic pc_illegal;

  // One-hot per-cycle actions, decoded by the output process.
  logic load_redirect;
  logic take_fault;
  logic take_fetch;

  assign instructionAddress = pc;
  assign advance            = !fetchValid || fetchReady;
  // Full 32-bit unsigned compare. A wrapped PC near 2^32 is out of range.
  assign pc_illegal         = (pc[1:0] != 2'b00) || (pc >= IMEM_LIMIT);

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= BOOT;
    end else begin
      state <= state_next;
    end
  end

  // --------------------------------------------------------------- next state
  always_comb begin
    state_next = state;
    case (state)
      BOOT: state_next = RUN;
      RUN: begin
        // A redirect takes priority and suppresses the fault check for the
        // PC that it replaces.
        if (!redirectValid && advance && pc_illegal) begin
          state_next = HALT;
        end
      end
      HALT:    state_next = HALT;
      default: state_next = BOOT;
    endcase
  end

  // ------------------------------------------------------------ output decode
  always_comb begin
    load_redirect = 1'b0;
    take_fault    = 1'b0;
    take_fetch    = 1'b0;
    case (state)
      BOOT: begin
        load_redirect = redirectValid;
      end
      RUN: begin
        if (redirectValid) begin
          load_redirect = 1'b1;
        end else if (advance) begin
          take_fault = pc_illegal;
          take_fetch = !pc_illegal;
        end
      end
      default: begin
        // HALT ignores redirect and ready. Only reset leaves it.
      end
    endcase
  end

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      pc           <= RESET_PC;
      fetchValid   <= 1'b0;
      fetchInstr   <= 32'h0;
      fetchPC      <= 32'h0;
      fault        <= 1'b0;
      faultAddress <= 32'h0;
    end else if (load_redirect) begin
      // Squash any held word, even one that decode accepts on this edge.
      pc         <= redirectTarget;
      fetchValid <= 1'b0;
    end else if (take_fault) begin
      fault        <= 1'b1;
      faultAddress <= pc;
      fetchValid   <= 1'b0;
    end else if (take_fetch) begin
      fetchValid <= 1'b1;
      fetchInstr <= instruction;
      fetchPC    <= pc;
      pc         <= pc + 32'd4;
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam int unsigned IMEM_BYTES = 256;

  logic        clk;
  logic        rst;
  logic [31:0] instructionAddress;
  logic [31:0] instruction;
  logic        redirectValid;
  logic [31:0] redirectTarget;
  logic        fetchValid;
  logic        fetchReady;
  logic [31:0] fetchInstr;
  logic [31:0] fetchPC;
  logic        fault;
  logic [31:0] faultAddress;

  int checks   = 0;
  int failures = 0;
  int handshakes   = 0;
  int fault_events = 0;

  // Expected delivery stream and the fault address that ends it.
  logic [31:0] exp_q[$];
  logic [31:0] exp_fault;
  int          dead = 0;   // steps since the stream ran dry with no new stream

  fetch_sequencer #(.RESET_PC(RESET_PC), .IMEM_BYTES(IMEM_BYTES)) dut (
    .clk(clk), .rst(rst),
    .instructionAddress(instructionAddress), .instruction(instruction),
    .redirectValid(redirectValid), .redirectTarget(redirectTarget),
    .fetchValid(fetchValid), .fetchReady(fetchReady),
    .fetchInstr(fetchInstr), .fetchPC(fetchPC),
    .fault(fault), .faultAddress(faultAddress)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents: word[i] = 0x1000 + i. Off-range reads return a marker.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a < IMEM_BYTES && a[1:0] == 2'b00) return 32'h1000 + (a >> 2);
    return 32'hDEAD_0000 | a[15:0];
  endfunction

  assign instruction = mem_word(instructionAddress);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // From a start address, decode sees every legal word in order up to the end
  // of memory. The first illegal address becomes the fault address.
  function automatic void build(input logic [31:0] t);
    exp_q.delete();
    if (t[1:0] == 2'b00 && t < IMEM_BYTES) begin
      for (logic [31:0] a = t; a < IMEM_BYTES; a += 4) exp_q.push_back(a);
      exp_fault = IMEM_BYTES;
    end else begin
      exp_fault = t;
    end
  endfunction

  // Wait for an edge, then drive inputs for the next edge. A redirect is
  // withheld for the one step in which the DUT may still be running toward
  // its fault. After that step, the DUT has halted and ignores redirects.
  task automatic step(input logic rdy, input logic rv, input logic [31:0] tgt, input logic rs);
    bit empty;
    @(posedge clk);
    #1;
    empty = (exp_q.size() == 0);
    if (empty && dead == 0) rv = 1'b0;
    rst            = rs;
    fetchReady     = rdy;
    redirectValid  = rv;
    redirectTarget = tgt;
    if (rs) begin
      build(RESET_PC);
      dead = 0;
    end else if (rv && !empty) begin
      build(tgt);
      dead = 0;
    end else if (empty) begin
      dead++;
    end
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_valid"}, {31'b0, fetchValid}, 32'h0);
    chk({tag, "_instr"}, fetchInstr, 32'h0);
    chk({tag, "_fpc"}, fetchPC, 32'h0);
    chk({tag, "_fault"}, {31'b0, fault}, 32'h0);
    chk({tag, "_faddr"}, faultAddress, 32'h0);
    chk({tag, "_iaddr"}, instructionAddress, RESET_PC);
  endtask

  function automatic logic [31:0] pick_target();
    case ($urandom_range(0, 9))
      0, 1, 2, 3, 4, 5: return {24'h0, 6'($urandom_range(0, 63)), 2'b00};
      6:                return 32'hF0 + 4 * $urandom_range(0, 3);
      7:                return 4 * $urandom_range(0, 63) + $urandom_range(1, 3);
      8:                return 32'h100 + 4 * $urandom_range(0, 1000);
      default:          return 32'hFFFF_FFFC;
    endcase
  endfunction

  // ------------------------------------------------------------------ monitor
  bit          stall_prev = 0;
  bit          fault_seen = 0;
  logic [31:0] s_pc, s_instr, s_ia;

  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_prev = 0;
        fault_seen = 0;
      end else begin
        if (stall_prev) begin
          chk("stall_valid", {31'b0, fetchValid}, 32'h1);
          chk("stall_fpc", fetchPC, s_pc);
          chk("stall_instr", fetchInstr, s_instr);
          chk("stall_iaddr", instructionAddress, s_ia);
        end
        if (fetchValid) chk("iaddr_ahead", instructionAddress, fetchPC + 32'd4);
        if (fault && !fault_seen) begin
          fault_seen = 1;
          fault_events++;
          chk("fault_addr", faultAddress, exp_fault);
          chk("fault_stream_done", exp_q.size(), 32'h0);
        end
        if (fault_seen && !fault) chk("fault_sticky", {31'b0, fault}, 32'h1);
        if (fault) chk("halt_no_valid", {31'b0, fetchValid}, 32'h0);
        if (fetchValid && fetchReady && !redirectValid) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_fetch", fetchPC, 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            chk("deliver_pc", fetchPC, e);
            chk("deliver_instr", fetchInstr, mem_word(e));
            handshakes++;
          end
        end
        stall_prev = fetchValid && !fetchReady && !redirectValid;
        s_pc = fetchPC;
        s_instr = fetchInstr;
        s_ia = instructionAddress;
      end
    end
  end

  // ----------------------------------------------------------------- stimulus
  initial begin
    rst = 1'b1; fetchReady = 1'b0; redirectValid = 1'b0; redirectTarget = 32'h0;
    build(RESET_PC);

    step(0, 0, 0, 1);
    step(1, 0, 0, 0);                 // reset applied
    reset_checks("por");
    step(1, 0, 0, 0);                 // BOOT -> RUN
    chk("boot_no_valid", {31'b0, fetchValid}, 32'h0);
    step(1, 0, 0, 0);
    chk("first_valid", {31'b0, fetchValid}, 32'h1);
    chk("first_pc", fetchPC, RESET_PC);
    chk("first_instr", fetchInstr, 32'h1000);
    step(1, 0, 0, 0);
    chk("second_pc", fetchPC, 32'h4);
    step(0, 0, 0, 0);
    chk("third_pc", fetchPC, 32'h8);
    step(0, 0, 0, 0);
    chk("hold_pc", fetchPC, 32'h8);
    chk("hold_iaddr", instructionAddress, 32'hC);
    step(0, 0, 0, 0);
    step(0, 1, 32'h40, 0);            // redirect with a held word
    chk("hold_pc3", fetchPC, 32'h8);
    step(1, 0, 0, 0);
    chk("redir_squash", {31'b0, fetchValid}, 32'h0);
    chk("redir_iaddr", instructionAddress, 32'h40);
    step(1, 0, 0, 0);
    chk("redir_pc", fetchPC, 32'h40);
    step(1, 1, 32'h42, 0);
    chk("redir_next_pc", fetchPC, 32'h44);
    step(1, 0, 0, 0);
    chk("mis_no_fault_yet", {31'b0, fault}, 32'h0);
    step(1, 1, 32'h0, 0);             // issued after the fault, so it is ignored
    chk("mis_fault", {31'b0, fault}, 32'h1);
    chk("mis_faddr", faultAddress, 32'h42);
    step(1, 0, 0, 0);
    chk("halt_ignores_redir", instructionAddress, 32'h42);
    chk("halt_fault_stays", {31'b0, fault}, 32'h1);

    step(1, 0, 0, 1);                 // reset out of HALT
    step(1, 1, 32'hF8, 0);            // redirect while in BOOT
    reset_checks("halt_rst");
    step(1, 0, 0, 0);
    chk("boot_redir_iaddr", instructionAddress, 32'hF8);
    step(1, 0, 0, 0);
    chk("end_pc_f8", fetchPC, 32'hF8);
    step(1, 0, 0, 0);
    chk("end_pc_fc", fetchPC, 32'hFC);
    step(1, 0, 0, 0);
    chk("end_fault", {31'b0, fault}, 32'h1);
    chk("end_faddr", faultAddress, 32'h100);

    step(1, 0, 0, 1);
    step(1, 0, 0, 0);
    reset_checks("rst2");
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 1);                 // reset with a held word
    step(1, 0, 0, 0);
    reset_checks("midrun_rst");
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("midrun_first_pc", fetchPC, RESET_PC);

    for (int i = 0; i < 4000; i++) begin
      logic rs;
      rs = ($urandom_range(0, 199) == 0) || (dead > 8 && $urandom_range(0, 3) == 0);
      step($urandom_range(0, 3) != 0, $urandom_range(0, 99) < 8, pick_target(), rs);
    end
    step(1, 0, 0, 0);

    chk("liveness_handshakes", {31'b0, handshakes > 300}, 32'h1);
    chk("liveness_faults", {31'b0, fault_events > 3}, 32'h1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
